// File: rtl/aq_ejpeg_zigzag.sv
// Ping-pong 8x8 coefficient buffer: pairs are written in natural (row-major) order,
// blocks are read back in JPEG zigzag order together with per-block color and LastNZ.
module aq_ejpeg_zigzag (
    input  logic        clk,
    input  logic        rst,
    input  logic        DataInit,
    input  logic        DataInEnable,
    input  logic [4:0]  DataInAddress,
    input  logic [15:0] DataInA,
    input  logic [15:0] DataInB,
    input  logic [2:0]  DataInColor,
    output logic        DataInIdle,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [15:0] OutData,
    output logic [5:0]  OutIndex,
    output logic        OutLast,
    output logic [2:0]  OutColor,
    output logic [5:0]  OutLastNZ,
    output logic        OutAllZeroAC
);

    // zigzag position -> natural index
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // natural index -> zigzag position
    localparam logic [5:0] NAT2ZZ [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rdState_t;

    logic [15:0] memA [64];
    logic [15:0] memB [64];
    logic [1:0]  full;
    logic [31:0] mask   [2];
    logic [2:0]  color  [2];
    logic [5:0]  lastNZ [2];
    logic        writeBank;
    logic        readBank;

    rdState_t    rdState, rdStateNext;
    logic        loadWord;
    logic        releaseBank;
    logic [5:0]  loadIdx;
    logic [5:0]  natIdx;
    logic [4:0]  pairIdx;
    logic [15:0] rdWord;

    logic        accept;
    logic        flush;
    logic [5:0]  zzA, zzB, nzNext;

    assign flush      = !rst || DataInit;
    assign DataInIdle = !full[writeBank];
    assign accept     = DataInEnable && !full[writeBank];
    assign OutValid   = (rdState == RD_STREAM);

    assign zzA = NAT2ZZ[{DataInAddress, 1'b0}];
    assign zzB = NAT2ZZ[{DataInAddress, 1'b1}];

    always_comb begin
        nzNext = lastNZ[writeBank];
        if (DataInA != '0 && zzA > nzNext) nzNext = zzA;
        if (DataInB != '0 && zzB > nzNext) nzNext = zzB;
    end

    // Reader: IDLE waits for a full read bank, STREAM holds one registered word.
    always_comb begin
        rdStateNext = rdState;
        loadWord    = 1'b0;
        releaseBank = 1'b0;
        loadIdx     = '0;
        case (rdState)
            RD_IDLE: begin
                if (full[readBank]) begin
                    loadWord    = 1'b1;
                    rdStateNext = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (OutReady) begin
                    if (OutLast) begin
                        releaseBank = 1'b1;
                        rdStateNext = RD_IDLE;
                    end else begin
                        loadWord = 1'b1;
                        loadIdx  = OutIndex + 6'd1;
                    end
                end
            end
            default: rdStateNext = RD_IDLE;
        endcase
    end

    // Pairs never written in this block are masked to zero instead of clearing memory.
    always_comb begin
        natIdx  = ZIGZAG[loadIdx];
        pairIdx = natIdx[5:1];
        rdWord  = '0;
        if (mask[readBank][pairIdx])
            rdWord = natIdx[0] ? memB[{readBank, pairIdx}] : memA[{readBank, pairIdx}];
    end

    always_ff @(posedge clk) begin
        if (flush) rdState <= RD_IDLE;
        else       rdState <= rdStateNext;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            memA[{writeBank, DataInAddress}] <= DataInA;
            memB[{writeBank, DataInAddress}] <= DataInB;
        end
    end

    // Writer and reader always own different banks, so completion and release never collide.
    always_ff @(posedge clk) begin
        if (flush) begin
            full      <= '0;
            mask[0]   <= '0;
            mask[1]   <= '0;
            lastNZ[0] <= '0;
            lastNZ[1] <= '0;
            color[0]  <= '0;
            color[1]  <= '0;
            writeBank <= 1'b0;
            readBank  <= 1'b0;
        end else begin
            if (accept) begin
                mask[writeBank][DataInAddress] <= 1'b1;
                lastNZ[writeBank]              <= nzNext;
                if (DataInAddress == 5'd31) begin
                    full[writeBank]  <= 1'b1;
                    color[writeBank] <= DataInColor;
                    writeBank        <= ~writeBank;
                end
            end
            if (releaseBank) begin
                full[readBank]   <= 1'b0;
                mask[readBank]   <= '0;
                lastNZ[readBank] <= '0;
                readBank         <= ~readBank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            OutData      <= '0;
            OutIndex     <= '0;
            OutLast      <= 1'b0;
            OutColor     <= '0;
            OutLastNZ    <= '0;
            OutAllZeroAC <= 1'b1;
        end else if (loadWord) begin
            OutData  <= rdWord;
            OutIndex <= loadIdx;
            OutLast  <= (loadIdx == 6'd63);
            if (rdState == RD_IDLE) begin
                OutColor     <= color[readBank];
                OutLastNZ    <= lastNZ[readBank];
                OutAllZeroAC <= (lastNZ[readBank] == 6'd0);
            end
        end
    end

endmodule
